// File: rtl/holy_core_pkg.sv
// Shared types and constants for the fetch/decode front end.
// Pure declarations: no logic, no latency, no flow control.
package holy_core_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_ALU_I  = 7'b001_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_R      = 7'b011_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_LUI    = 7'b011_0111;
    localparam logic [6:0] OP_AUIPC  = 7'b001_0111;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem request, decoded fields, next-PC select.
// Retire-to-present is 3 cycles with a zero-wait memory; request held until accepted, instr held until retired.
module fetch_unit
    import holy_core_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_four,
    input  logic            pc_source,
    input  logic [XLEN-1:0] pc_target,
    output logic            fetch_fault,
    output logic [31:0]     instret
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     instret_q, instret_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] pc_inc;

    assign pc_inc = pc_q + XLEN'(4);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        fault_d   = fault_q;
        case (state_q)
            REQ: begin
                if (imem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    instret_d = instret_q + 32'd1;
                    // Drop back to NOP so the decoded fields read as NOP while nothing is presented.
                    instr_d   = NOP_INSTR;
                    state_d   = REQ;
                    if (!pc_source) begin
                        pc_d = pc_inc;
                    end else if (pc_target[1:0] == 2'b00) begin
                        pc_d = pc_target;
                    end else begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            instret_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    // Reset is folded in so no request escapes while the memory is itself held in reset.
    assign imem_req_valid = rst_n && (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == HOLD);
    assign instr          = instr_q;
    assign op             = instr_q[6:0];
    assign func3          = instr_q[14:12];
    assign func7          = instr_q[31:25];
    assign rs1            = instr_q[19:15];
    assign rs2            = instr_q[24:20];
    assign rd             = instr_q[11:7];
    assign pc             = pc_q;
    assign pc_plus_four   = pc_inc;
    assign fetch_fault    = fault_q;
    assign instret        = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural 1-cycle imem, PC/retire model, scoreboard of expected fetches.
// Inputs change 1 unit after the rising edge; outputs are sampled on the falling edge or after the edge.
module tb_fetch_unit;
    import holy_core_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc_plus_four;
    logic        pc_source;
    logic [31:0] pc_target;
    logic        fetch_fault;
    logic [31:0] instret;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .op             (op),
        .func3          (func3),
        .func7          (func7),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .pc             (pc),
        .pc_plus_four   (pc_plus_four),
        .pc_source      (pc_source),
        .pc_target      (pc_target),
        .fetch_fault    (fetch_fault),
        .instret        (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_err;
    int          n_acc;
    logic [31:0] exp_pc;
    logic [31:0] exp_instret;
    logic        exp_fault;
    logic [31:0] sb_q[$];
    logic        rsp_pend;
    logic [31:0] rsp_addr;
    logic        spur;
    logic [31:0] last_pc;
    logic [31:0] last_instr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock: observe accepts/retires before the edge, drive memory response after it.
    task automatic tick();
        @(negedge clk);
        rsp_pend = 1'b0;
        if (!rst_n) begin
            exp_pc      = RST_PC;
            exp_instret = 32'd0;
            exp_fault   = 1'b0;
            sb_q.delete();
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                n_acc++;
                check_eq("req_addr", imem_req_addr, exp_pc);
                sb_q.push_back(exp_pc);
                rsp_pend = 1'b1;
                rsp_addr = imem_req_addr;
            end
            if (instr_valid && instr_ready) begin
                exp_instret = exp_instret + 32'd1;
                if (!pc_source)                exp_pc = exp_pc + 32'd4;
                else if (pc_target[1:0] != 0)  exp_fault = 1'b1;
                else                           exp_pc = pc_target;
            end
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = rsp_pend | spur;
        imem_rsp_data  = rsp_pend ? mem_word(rsp_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic wait_present(input int budget);
        logic [31:0] e;
        logic [31:0] w;
        for (int i = 0; i < budget && !instr_valid; i++) tick();
        check_eq("present", 32'(instr_valid), 32'd1);
        check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
        if (instr_valid && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            w = mem_word(e);
            last_pc    = e;
            last_instr = w;
            check_eq("instr", instr, w);
            check_eq("pc", pc, e);
            check_eq("pc_plus_four", pc_plus_four, e + 32'd4);
            check_eq("op", 32'(op), 32'(w[6:0]));
            check_eq("func3", 32'(func3), 32'(w[14:12]));
            check_eq("func7", 32'(func7), 32'(w[31:25]));
            check_eq("rs1", 32'(rs1), 32'(w[19:15]));
            check_eq("rs2", 32'(rs2), 32'(w[24:20]));
            check_eq("rd", 32'(rd), 32'(w[11:7]));
        end
    endtask

    task automatic retire(input logic src, input logic [31:0] tgt);
        instr_ready = 1'b1;
        pc_source   = src;
        pc_target   = tgt;
        tick();
        instr_ready = 1'b0;
        pc_source   = 1'b0;
        pc_target   = 32'h0;
        check_eq("instret", instret, exp_instret);
        check_eq("valid_drop", 32'(instr_valid), 32'd0);
        check_eq("nop_op", 32'(op), 32'(NOP_INSTR[6:0]));
    endtask

    initial begin
        int n0;
        n_chk = 0; n_err = 0; n_acc = 0;
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        instr_ready = 1'b0; pc_source = 1'b0; pc_target = 32'h0; spur = 1'b0; rsp_pend = 1'b0;
        rsp_addr = 32'h0; exp_pc = RST_PC; exp_instret = 32'd0; exp_fault = 1'b0;
        last_pc = 32'h0; last_instr = 32'h0;

        // Reset state and first fetch sequence
        tick(); tick();
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, NOP_INSTR);
        check_eq("rst_pc", pc, RST_PC);
        check_eq("rst_fault", 32'(fetch_fault), 32'd0);
        check_eq("rst_instret", instret, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("t1_valid_edge1", 32'(instr_valid), 32'd0);
        tick();
        check_eq("t1_valid_edge2", 32'(instr_valid), 32'd1);
        wait_present(1);
        retire(1'b0, 32'h0);
        wait_present(8);
        retire(1'b0, 32'h0);
        wait_present(8);
        check_eq("t1_pc3", pc, RST_PC + 32'd8);

        // Request stalled by memory for 4 cycles
        imem_req_ready = 1'b0;
        retire(1'b0, 32'h0);
        n0 = n_acc;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t2_req_valid", 32'(imem_req_valid), 32'd1);
            check_eq("t2_req_addr", imem_req_addr, RST_PC + 32'd12);
        end
        imem_req_ready = 1'b1;
        wait_present(8);
        check_eq("t2_accepts", 32'(n_acc - n0), 32'd1);

        // Taken redirect
        retire(1'b1, 32'h0000_0200);
        wait_present(8);
        check_eq("t3_pc", pc, 32'h0000_0200);
        check_eq("t3_pc4", pc_plus_four, 32'h0000_0204);

        // Core stalls in HOLD while memory fires spurious responses
        spur = 1'b1;
        n0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t5_instr", instr, last_instr);
            check_eq("t5_pc", pc, last_pc);
            check_eq("t5_req_valid", 32'(imem_req_valid), 32'd0);
            check_eq("t5_instr_valid", 32'(instr_valid), 32'd1);
        end
        spur = 1'b0;
        tick();
        check_eq("t5_instr_end", instr, last_instr);
        check_eq("t5_no_accept", 32'(n_acc - n0), 32'd0);

        // PC wrap, then reset in the middle of WAIT
        retire(1'b1, 32'hFFFF_FFFC);
        wait_present(8);
        check_eq("t6_pc4_wrap", pc_plus_four, 32'h0000_0000);
        retire(1'b0, 32'h0);
        tick();
        check_eq("t6_wrap_addr_seen", 32'(sb_q.size()), 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("t6_rst_pc", pc, RST_PC);
        check_eq("t6_rst_instret", instret, 32'd0);
        check_eq("t6_rst_valid", 32'(instr_valid), 32'd0);
        rst_n = 1'b1;
        wait_present(8);
        check_eq("t6_refetch_pc", pc, RST_PC);

        // Misaligned redirect: sticky fault, fetch stops
        retire(1'b1, 32'h0000_0202);
        check_eq("t4_instret", instret, 32'd1);
        check_eq("t4_fault", 32'(fetch_fault), 32'd1);
        n0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("t4_req_valid", 32'(imem_req_valid), 32'd0);
            check_eq("t4_instr_valid", 32'(instr_valid), 32'd0);
            check_eq("t4_fault_sticky", 32'(fetch_fault), 32'(exp_fault));
        end
        check_eq("t4_no_accept", 32'(n_acc - n0), 32'd0);
        check_eq("t4_pc_held", pc, RST_PC);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
